// File: rtl/lbp_hist.sv
`default_nettype none
// ============================================================================
// Module   : lbp_hist
// Purpose  : Builds a 10-bin uniform-LBP histogram over the 36 interior
//            pixels of an 8x8 LBP code map. It reads the codes from an
//            external memory and writes the bins to a histogram memory.
//            Bins 0..8 hold uniform codes, indexed by their number of ones.
//            Bin 9 holds all non-uniform codes.
// Ports    : clk        - single clock, rising edge
//            reset      - asynchronous, active-low
//            start      - begin a run (sampled in IDLE only)
//            lbp_req    - LBP memory read request
//            lbp_addr   - LBP memory address, row-major 8x8
//            lbp_data   - LBP code, valid at the edge after its request
//            hist_write - histogram write strobe (one high cycle per bin)
//            hist_addr  - bin index 0..9
//            hist_data  - bin count
//            finish     - histogram fully written; held until reset
// Revision : 1.0 - initial release
// ============================================================================
module lbp_hist #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             lbp_req,
    output logic [5:0]       lbp_addr,
    input  logic [7:0]       lbp_data,
    output logic             hist_write,
    output logic [3:0]       hist_addr,
    output logic [CNT_W-1:0] hist_data,
    output logic             finish
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0]       c_FIRST_RC = 3'd1;
    localparam logic [2:0]       c_LAST_RC  = 3'd6;
    localparam logic [3:0]       c_LAST_BIN = 4'd9;
    localparam logic [CNT_W-1:0] c_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [2:0]       row_q, row_d;
    logic [2:0]       col_q, col_d;
    logic [7:0]       pix_q, pix_d;
    logic             pix_vld_q, pix_vld_d;
    logic [CNT_W-1:0] bins_q [10];
    logic [CNT_W-1:0] bins_d [10];
    logic [3:0]       bin_q, bin_d;
    logic             phase_q, phase_d;
    logic [3:0]       w_pix_bin;

    // Uniform codes (at most two circular 0/1 transitions) map to their
    // number of ones. All other codes map to bin 9.
    function automatic logic [3:0] classify(input logic [7:0] p);
        logic [7:0] t;
        logic [3:0] u;
        logic [3:0] ones;
        t    = p ^ {p[6:0], p[7]};
        u    = 4'd0;
        ones = 4'd0;
        for (int i = 0; i < 8; i++) begin
            u    = u + {3'b000, t[i]};
            ones = ones + {3'b000, p[i]};
        end
        classify = (u <= 4'd2) ? ones : c_LAST_BIN;
    endfunction

    assign w_pix_bin = classify(pix_q);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        pix_d     = pix_q;
        pix_vld_d = 1'b0;
        bins_d    = bins_q;
        bin_d     = bin_q;
        phase_d   = phase_q;

        // Two-stage pipeline. At each edge with a request, the returned code
        // is captured into pix_q. At the following edge its bin is
        // incremented. The DRAIN cycle performs the increment for the last
        // pixel.
        if (pix_vld_q) begin
            bins_d[w_pix_bin] = bins_q[w_pix_bin] + c_ONE;
        end
        if (lbp_req) begin
            pix_d     = lbp_data;
            pix_vld_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    row_d   = c_FIRST_RC;
                    col_d   = c_FIRST_RC;
                    for (int i = 0; i < 10; i++) begin
                        bins_d[i] = '0;
                    end
                end
            end
            S_READ: begin
                if (col_q == c_LAST_RC) begin
                    col_d = c_FIRST_RC;
                    if (row_q == c_LAST_RC) begin
                        state_d = S_DRAIN;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_WRITE;
                bin_d   = 4'd0;
                phase_d = 1'b0;
            end
            S_WRITE: begin
                // phase 0 is the strobe-high cycle and phase 1 the strobe-low cycle.
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (bin_q == c_LAST_BIN) begin
                        state_d = S_DONE;
                    end else begin
                        bin_d = bin_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            row_q     <= 3'd0;
            col_q     <= 3'd0;
            pix_q     <= 8'd0;
            pix_vld_q <= 1'b0;
            bin_q     <= 4'd0;
            phase_q   <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                bins_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pix_q     <= pix_d;
            pix_vld_q <= pix_vld_d;
            bin_q     <= bin_d;
            phase_q   <= phase_d;
            bins_q    <= bins_d;
        end
    end

    // The outputs are decoded directly from the state. A reset therefore
    // forces them low immediately, without waiting for a clock edge.
    assign lbp_req    = (state_q == S_READ);
    assign lbp_addr   = lbp_req ? {row_q, col_q} : 6'd0;
    assign hist_write = (state_q == S_WRITE) && !phase_q;
    assign hist_addr  = (state_q == S_WRITE) ? bin_q : 4'd0;
    assign hist_data  = (state_q == S_WRITE) ? bins_q[bin_q] : '0;
    assign finish     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: doc/lbp_hist.md
LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 SHALL have parameter CNT_W, default 6, giving the width of each bin count (36 maximum).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, sampled in IDLE to begin processing (driven by the LBP stage finish).
REQ-005 SHALL have port lbp_req, output, 1, read request to the LBP result memory.
REQ-006 SHALL have port lbp_addr, output, 6, LBP memory read address, row-major 8x8.
REQ-007 SHALL have port lbp_data, input, 8, LBP code; memory updates it on the negedge where lbp_req is high.
REQ-008 SHALL have port hist_write, output, 1, histogram write strobe; memory captures on its rising edge.
REQ-009 SHALL have port hist_addr, output, 4, bin index 0..9.
REQ-010 SHALL have port hist_data, output, CNT_W, bin count.
REQ-011 SHALL have port finish, output, 1, high when the histogram is fully written.

Function
REQ-012 SHALL use states IDLE, READ, DRAIN, WRITE, DONE.
REQ-013 SHALL move IDLE->READ on the first rising edge where start=1; otherwise it SHALL stay in IDLE.
REQ-014 SHALL, in READ, issue one request per cycle (lbp_req=1) for the 36 interior pixels only: rows 1..6, cols 1..6, addr = row*8+col, ascending order 9,10..14,17..54; border addresses SHALL never be requested.
REQ-015 SHALL sample lbp_data at the rising edge one cycle after the cycle in which its address was presented (1-cycle read latency), pipelined so that one pixel is accepted per cycle.
REQ-016 SHALL classify each code p by U = popcount(p XOR rotl(p,1)) over 8 circular bits: if U<=2, bin = popcount(p) (0..8); otherwise bin = 9.
REQ-017 SHALL increment the selected bin by 1 per accepted pixel; counts SHALL be CNT_W-bit and never saturate or wrap for the 36-pixel case.
REQ-018 SHALL enter DRAIN after the last request, deassert lbp_req, and accumulate the final sampled pixel before entering WRITE.
REQ-019 SHALL, in WRITE, output bins 0..9 in order; each bin uses 2 cycles: hist_write=1 then hist_write=0, with hist_addr/hist_data stable across both cycles.
REQ-020 SHALL emit exactly 10 hist_write rising edges per run.
REQ-021 SHALL enter DONE after bin 9's low cycle, assert finish=1, and hold it until reset; start SHALL be ignored in DONE.
REQ-022 SHALL assert finish no later than 64 cycles after start is sampled.
REQ-023 SHALL keep lbp_req=0 outside READ and hist_write=0 outside WRITE.
REQ-024 SHALL clear all bin counters on entry to READ so that no stale counts are carried over.

Reset
REQ-025 SHALL, while reset=0, force state=IDLE, lbp_req=0, lbp_addr=0, hist_write=0, hist_addr=0, hist_data=0, finish=0, and all counters to 0, regardless of the clock.
REQ-026 SHALL, on reset asserted mid-READ or mid-WRITE, abort immediately with no further strobes; a later start SHALL begin a complete fresh run.

Verification
REQ-027 SHALL pass this test: all 64 LBP entries = 0x00, start pulse -> bin0 = 36, bins 1..9 = 0, finish=1, 10 write strobes.
REQ-028 SHALL pass this test: all entries = 0xFF -> bin8 = 36, others 0; all entries = 0x55 -> bin9 = 36, others 0.
REQ-029 SHALL pass this test: interior filled cyclically with 0x01, 0x0F, 0x81, 0x55, border = 0xAA -> bin1 = 9, bin2 = 9, bin4 = 9, bin9 = 9; a monitor confirms no border address is ever requested.
REQ-030 SHALL pass this test: start held high continuously -> exactly one run, and finish stays high with no further lbp_req or hist_write.
REQ-031 SHALL pass this test: reset=0 applied at cycle 20 of READ -> all outputs 0 asynchronously; a new start with all entries 0x00 -> bin0 = 36.
REQ-032 SHALL pass this test: timing check -> each lbp_data is sampled exactly 1 cycle after its address, and hist_addr/hist_data are stable while hist_write is high.
